// File: rtl/weight_stream_reader.sv
// weight_stream_reader
//
// Read-side sequencer for one ANN weight BRAM. A START pulse walks the
// BRAM from address 0 to DEPTH-1. Each weight is presented on a
// valid/ready stream to the neuron MAC. A 2-entry output buffer absorbs
// back-pressure, so no word is ever dropped or repeated.
//
// The BRAM samples its address on the falling clock edge and returns data
// one cycle after the read was issued. All logic in this module runs on the
// rising edge.
//
// Parameters
//   DEPTH  number of weights streamed per START
//   AW     BRAM address width (2**AW must be >= DEPTH)
//   DW     weight data width
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   start      begin a stream (only honoured while idle)
//   abort      synchronous flush back to idle, highest priority
//   busy       high while fetching or draining
//   done       one-cycle pulse after the last word's handshake
//   bram_addr  read address to the BRAM
//   bram_en    read enable to the BRAM
//   bram_we    write enable to the BRAM (always 0)
//   bram_di    write data to the BRAM (always 0)
//   bram_do    read data from the BRAM
//   w_data     weight at the buffer head
//   w_valid    w_data is valid
//   w_ready    consumer accepts w_data
//   w_last     head word is the final address
//   w_index    address of the head word

module weight_stream_reader #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] bram_addr,
    output logic          bram_en,
    output logic          bram_we,
    output logic [DW-1:0] bram_di,
    input  logic [DW-1:0] bram_do,
    output logic [DW-1:0] w_data,
    output logic          w_valid,
    input  logic          w_ready,
    output logic          w_last,
    output logic [AW-1:0] w_index
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] issue_cnt;

    // Output buffer: two entries of {data, index} with 1-bit pointers.
    logic [DW-1:0] buf_data  [2];
    logic [AW-1:0] buf_index [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    occ;

    logic          push;
    logic          pop;
    logic [1:0]    occ_next;
    logic          issue;
    logic          last_pop;
    logic [DW-1:0] head_data;
    logic [AW-1:0] head_index;

    // A read issued last cycle (bram_en still high) has its data on bram_do
    // now, so the registered enable doubles as the in-flight flag.
    assign push = bram_en;
    assign pop  = w_valid & w_ready;

    // The buffer occupancy after this edge if no new read is issued.
    // A read issued now lands one edge later. So a read is only issued when
    // occupancy leaves room for it, which keeps the buffer at two entries
    // or fewer.
    always_comb begin
        occ_next = occ + {1'b0, push} - {1'b0, pop};
        issue    = 1'b0;
        if (!abort && (occ_next <= 2'd1)) begin
            if (state == FETCH) begin
                issue = 1'b1;
            end else if (state == IDLE && start) begin
                issue = 1'b1;
            end
        end
    end

    assign head_data  = buf_data[rd_ptr];
    assign head_index = buf_index[rd_ptr];
    assign last_pop   = pop && (head_index == LAST_ADDR);

    // Control path: state machine, read issue, buffer pointers and the done
    // pulse. Abort flushes everything and suppresses done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            issue_cnt <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occ       <= 2'd0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            issue_cnt <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occ       <= 2'd0;
            done      <= 1'b0;
        end else begin
            done    <= 1'b0;
            bram_en <= issue;

            // The first read of a stream always targets address 0,
            // whatever the counter held before.
            if (issue) begin
                if (state == IDLE) begin
                    bram_addr <= '0;
                    issue_cnt <= AW'(1);
                end else begin
                    bram_addr <= issue_cnt;
                    issue_cnt <= issue_cnt + AW'(1);
                end
            end

            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ_next;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= (DEPTH == 1) ? DRAIN : FETCH;
                    end
                end
                FETCH: begin
                    if (issue && (issue_cnt == LAST_ADDR)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        issue_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Buffer storage needs no reset. Output gating hides stale contents
    // whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push && !abort) begin
            buf_data[wr_ptr]  <= bram_do;
            buf_index[wr_ptr] <= bram_addr;
        end
    end

    assign busy    = (state != IDLE);
    assign w_valid = (occ != 2'd0);
    assign w_data  = w_valid ? head_data  : '0;
    assign w_index = w_valid ? head_index : '0;
    assign w_last  = w_valid && (head_index == LAST_ADDR);

    // The port is read-only from this side.
    assign bram_we = 1'b0;
    assign bram_di = '0;

endmodule

// File: tb/tb_weight_stream_reader.sv
// tb_weight_stream_reader
//
// Directed bench for weight_stream_reader with a falling-edge BRAM model.
// Scenarios covered:
//   - reset values
//   - a full-rate stream
//   - a back-pressured stream (random ready, plus a long stall at index 5)
//   - START while busy
//   - ABORT with a full buffer, followed by a restart
//   - asynchronous reset mid-stream

module tb_weight_stream_reader;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic          bram_we;
    logic [DW-1:0] bram_di;
    logic [DW-1:0] bram_do;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;
    logic [AW-1:0] w_index;

    int tests_run = 0;
    int failures  = 0;

    logic [DW-1:0] bram_mem [DEPTH];

    weight_stream_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_di   (bram_di),
        .bram_do   (bram_do),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_last    (w_last),
        .w_index   (w_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, easily recognisable weight per address.
    function automatic logic [DW-1:0] weight(input int idx);
        logic [DW-1:0] v;
        v = DW'(idx * 311) ^ 16'h5A5A;
        return v;
    endfunction

    // BRAM model: the read happens on the falling edge and the data is held
    // until the next read.
    always @(negedge clk) begin
        if (bram_en && (int'(bram_addr) < DEPTH)) begin
            bram_do <= bram_mem[bram_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Pulse start for one edge and check the first read issue.
    task automatic applyStimulus();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("start_busy",  busy,      1);
        checkOutput("start_en",    bram_en,   1);
        checkOutput("start_addr",  bram_addr, 0);
        checkOutput("start_valid", w_valid,   0);
    endtask

    // Consume one stream.
    //   mode 0: ready held high, valid must be continuous.
    //   mode 1: ready is random, with a 10-cycle stall at index 5.
    //   start_idx >= 0: pulse start while that index is at the head.
    //   abort_idx >= 0: stall at that index until full, then abort.
    task automatic consume_stream(input int mode, input int start_idx,
                                  input int abort_idx);
        int exp_idx     = 0;
        int issued      = 1;
        int popped      = 0;
        int stall_cnt   = 0;
        int abort_stall = 0;
        int cycles      = 0;
        bit last_popped = 0;
        bit finished    = 0;
        bit aborted     = 0;
        bit start_sent  = 0;
        while (!finished && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
            start = 1'b0;
            checkOutput("bram_we", bram_we, 0);
            checkOutput("bram_di", bram_di, 0);
            if (aborted) begin
                abort = 1'b0;
                checkOutput("abort_valid", w_valid,   0);
                checkOutput("abort_busy",  busy,      0);
                checkOutput("abort_en",    bram_en,   0);
                checkOutput("abort_done",  done,      0);
                checkOutput("abort_addr",  bram_addr, 0);
                checkOutput("abort_data",  w_data,    0);
                finished = 1;
                continue;
            end
            if (bram_en) begin
                issued++;
                checkOutput("issue_addr", bram_addr, issued - 1);
            end
            checkOutput("credit", (issued - popped) <= 2, 1);
            if (last_popped) begin
                checkOutput("done_pulse",  done,    1);
                checkOutput("done_busy",   busy,    0);
                checkOutput("done_valid",  w_valid, 0);
                finished = 1;
                continue;
            end
            checkOutput("no_done", done, 0);
            checkOutput("busy",    busy, 1);
            if (mode == 0) begin
                checkOutput("full_rate_valid", w_valid, 1);
            end
            if (w_valid) begin
                checkOutput("w_index", w_index, exp_idx);
                checkOutput("w_data",  w_data,  weight(exp_idx));
                checkOutput("w_last",  w_last,  exp_idx == DEPTH - 1);
            end
            if (mode == 0) begin
                w_ready = 1'b1;
            end else if (exp_idx == 5 && stall_cnt < 10) begin
                w_ready = 1'b0;
                if (w_valid) stall_cnt++;
            end else begin
                w_ready = 1'($urandom_range(0, 1));
            end
            if (abort_idx >= 0 && exp_idx == abort_idx && w_valid) begin
                w_ready = 1'b0;
                abort_stall++;
                if (abort_stall >= 4) begin
                    checkOutput("abort_full", issued - popped, 2);
                    checkOutput("abort_idle_en", bram_en, 0);
                    abort   = 1'b1;
                    aborted = 1;
                end
            end
            if (start_idx >= 0 && exp_idx == start_idx && w_valid && !start_sent) begin
                start      = 1'b1;
                start_sent = 1;
            end
            if (w_valid && w_ready) begin
                popped++;
                if (exp_idx == DEPTH - 1) last_popped = 1;
                exp_idx++;
            end
        end
        if (!finished) begin
            checkOutput("timeout", 0, 1);
        end
        w_ready = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
    endtask

    // One cycle after a completed stream: quiet and idle.
    task automatic check_idle_after(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done"},  done,    0);
        checkOutput({tag, "_valid"}, w_valid, 0);
        checkOutput({tag, "_busy"},  busy,    0);
        checkOutput({tag, "_en"},    bram_en, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) bram_mem[i] = weight(i);
        bram_do = '0;
        rst_n   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        w_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy",  busy,      0);
        checkOutput("rst_done",  done,      0);
        checkOutput("rst_valid", w_valid,   0);
        checkOutput("rst_en",    bram_en,   0);
        checkOutput("rst_addr",  bram_addr, 0);
        checkOutput("rst_data",  w_data,    0);
        checkOutput("rst_last",  w_last,    0);
        checkOutput("rst_index", w_index,   0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] full-rate stream");
        applyStimulus();
        consume_stream(0, -1, -1);
        check_idle_after("full_after");

        $display("[TB] back-pressure stream");
        applyStimulus();
        consume_stream(1, -1, -1);
        check_idle_after("bp_after");

        $display("[TB] start while busy");
        applyStimulus();
        consume_stream(0, 12, -1);
        check_idle_after("restart_after");

        $display("[TB] abort with full buffer");
        applyStimulus();
        consume_stream(1, -1, 20);
        check_idle_after("abort_after");
        applyStimulus();
        consume_stream(0, -1, -1);
        check_idle_after("post_abort_after");

        $display("[TB] reset mid-stream");
        applyStimulus();
        w_ready = 1'b1;
        for (int i = 0; i < 4; i++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", w_valid,   0);
        checkOutput("mid_rst_busy",  busy,      0);
        checkOutput("mid_rst_en",    bram_en,   0);
        checkOutput("mid_rst_addr",  bram_addr, 0);
        checkOutput("mid_rst_data",  w_data,    0);
        checkOutput("mid_rst_index", w_index,   0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_valid", w_valid, 0);
            checkOutput("post_rst_busy",  busy,    0);
        end
        w_ready = 1'b0;
        applyStimulus();
        consume_stream(0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
